// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares one synchronous FIFO write port between two
// valid/ready producers using round-robin arbitration with burst hold.
// A credit counter mirrors FIFO occupancy, so the FIFO can never overflow.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   s0_valid/data/ready     producer 0 handshake (ready is combinational)
//   s1_valid/data/ready     producer 1 handshake (ready is combinational)
//   fifo_rd_en              consumer read strobe; returns one credit
//   fifo_wr_en/wr_data      registered FIFO write strobe and word
//   credits                 free FIFO slots as tracked here
//
// Build option: define FIFO_ARB_FIXED_PRI_EN for fixed priority (producer 0
// wins in IDLE). Without it, round-robin arbitration is used.
module fifo_write_arbiter #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int BURST = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s0_valid,
    input  logic [DW-1:0] s0_data,
    output logic          s0_ready,
    input  logic          s1_valid,
    input  logic [DW-1:0] s1_data,
    output logic          s1_ready,
    input  logic          fifo_rd_en,
    output logic          fifo_wr_en,
    output logic [DW-1:0] fifo_wr_data,
    output logic [CW-1:0] credits
);

    localparam int BW = $clog2(BURST + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [BW-1:0] BMAX = BW'(BURST);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state;
    logic          owner;
    logic [BW-1:0] burst_cnt;

    logic owner_valid;
    logic hold;
    logic pick_valid;
    logic pick;
    logic pair_pick;
    logic has_credit;
    logic accept;
    logic rd_ok;
    logic rel;
    logic rel_id;

`ifdef FIFO_ARB_FIXED_PRI_EN
    assign pair_pick = 1'b0;
`else
    logic last_grant;

    // Remembers who released the grant last, so a contended IDLE cycle
    // goes to the other producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (rel) begin
            last_grant <= rel_id;
        end
    end

    assign pair_pick = ~last_grant;
`endif

    always_comb begin
        owner_valid = owner ? s1_valid : s0_valid;
        // An owner that drops valid loses the grant in the same cycle,
        // letting the other producer be served without a bubble.
        hold       = (state == HOLD) && owner_valid;
        pick_valid = 1'b0;
        pick       = 1'b0;
        if (hold) begin
            pick_valid = 1'b1;
            pick       = owner;
        end else if (s0_valid && s1_valid) begin
            pick_valid = 1'b1;
            pick       = pair_pick;
        end else if (s0_valid) begin
            pick_valid = 1'b1;
            pick       = 1'b0;
        end else if (s1_valid) begin
            pick_valid = 1'b1;
            pick       = 1'b1;
        end
    end

    assign has_credit = (credits != '0);
    assign accept     = rst_n && has_credit && pick_valid;
    assign s0_ready   = accept && !pick;
    assign s1_ready   = accept && pick;
    // A read with a full credit count means the FIFO is empty; ignore it.
    assign rd_ok      = fifo_rd_en && (credits != FULL);

    // The grant is released when the burst completes or the owner leaves.
    always_comb begin
        rel    = 1'b0;
        rel_id = accept ? pick : owner;
        if (accept && !hold && BMAX == BW'(1)) begin
            rel = 1'b1;
        end else if (accept && hold && burst_cnt == BMAX - BW'(1)) begin
            rel = 1'b1;
        end else if (!accept && state == HOLD && !owner_valid) begin
            rel = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= 1'b0;
            burst_cnt    <= '0;
            credits      <= FULL;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            fifo_wr_en <= accept;
            if (accept) begin
                fifo_wr_data <= pick ? s1_data : s0_data;
            end

            if (accept && !rd_ok) begin
                credits <= credits - 1'b1;
            end else if (!accept && rd_ok) begin
                credits <= credits + 1'b1;
            end

            if (rel) begin
                state     <= IDLE;
                burst_cnt <= '0;
            end else if (accept && !hold) begin
                state     <= HOLD;
                owner     <= pick;
                burst_cnt <= BW'(1);
            end else if (accept) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

endmodule
